// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline slice: depth limit, occupancy
// width helper and the per-stage hold/load/clear command encoding.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

  // What a single stage register does at the next falling edge.
  typedef enum logic [1:0] {
    STAGE_HOLD  = 2'b00,
    STAGE_LOAD  = 2'b01,
    STAGE_CLEAR = 2'b10
  } stage_cmd_e;

  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Flush wins; an open stage takes its source's valid, a blocked stage holds.
  function automatic stage_cmd_e stage_cmd(input logic flush,
                                           input logic open,
                                           input logic src_valid);
    if (flush) return STAGE_CLEAR;
    if (!open) return STAGE_HOLD;
    return src_valid ? STAGE_LOAD : STAGE_CLEAR;
  endfunction

endpackage

// File: rtl/pipe_slice_stage.sv
// One valid-tagged register of the pipeline slice, updated on the falling edge.
// PIPE_SLICE_CLEAR_DATA_EN: also zero the payload whenever the stage empties.
module pipe_slice_stage #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [N-1:0] din,
  output logic         valid,
  output logic [N-1:0] data
);

  logic         v_q, v_d;
  logic [N-1:0] d_q, d_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    v_d = v_q;
    d_d = d_q;
    if (clear) begin
      v_d = 1'b0;
`ifdef PIPE_SLICE_CLEAR_DATA_EN
      d_d = '0;
`endif
    end else if (load) begin
      v_d = 1'b1;
      d_d = din;
    end
  end

  // NOTE: the payload register is reset too, so out_data is 0 straight out of reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid = v_q;
  assign data  = d_q;

endmodule

// File: rtl/pipe_slice.sv
// Elastic DEPTH-stage pipeline register with valid/ready, bubble collapse and flush.
// Optional PIPE_SLICE_CLEAR_DATA_EN zeroes payload of empty stages (see pipe_slice_stage).
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int N     = 128,
  parameter int DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [N-1:0]     d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] open;

  // Ready ripples backwards from out_ready through every stage in one cycle.
  always_comb begin
    logic nxt_open;
    adv      = '0;
    open     = '0;
    nxt_open = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]   = v[i] & nxt_open;
      open[i]  = ~v[i] | adv[i];
      nxt_open = open[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic       src_valid;
    logic [N-1:0] src_data;
    stage_cmd_e cmd;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = d[i-1];
    end

    assign cmd = stage_cmd(flush, open[i], src_valid);

    pipe_slice_stage #(.N(N)) u_stage (
      .clk   (clk),
      .reset (reset),
      .load  (cmd == STAGE_LOAD),
      .clear (cmd == STAGE_CLEAR),
      .din   (src_data),
      .valid (v[i]),
      .data  (d[i])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  // A flushed input beat is swallowed, so the source never stalls on flush.
  assign in_ready  = open[0] | flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_slice.sv
// Self-checking bench for pipe_slice (DEPTH=3, N=8): table-driven cycles with a
// scoreboard queue for payload ordering, plus reset and async-reset sequences.
module tb_pipe_slice;

  localparam int N     = 8;
  localparam int DEPTH = 3;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;

  pipe_slice #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_data;
    logic [1:0] e_occ;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic fl, input logic iv, input logic [7:0] id,
                               input logic ordy, input logic e_irdy, input logic e_ov,
                               input logic [7:0] e_data, input logic [1:0] e_occ);
    vec_t r;
    r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_data = e_data; r.e_occ = e_occ;
    return r;
  endfunction

  // Entered just after a rising edge; the state seen here was set by the previous falling edge.
  task automatic do_row(input int idx, input vec_t r);
    logic [7:0] exp_d;
    #1;
    flush = r.fl; in_valid = r.iv; in_data = r.id; out_ready = r.ordy;
    #1;
    check($sformatf("row%0d_in_ready", idx), in_ready, r.e_irdy);
    check($sformatf("row%0d_out_valid", idx), out_valid, r.e_ov);
    check($sformatf("row%0d_occupancy", idx), occupancy, r.e_occ);
    if (r.e_ov) check($sformatf("row%0d_out_data", idx), out_data, r.e_data);
`ifdef PIPE_SLICE_CLEAR_DATA_EN
    else check($sformatf("row%0d_out_data_zero", idx), out_data, 0);
`endif
    if (out_valid && r.ordy) begin
      if (sb.size() == 0) begin
        check($sformatf("row%0d_sb_underflow", idx), out_data, 32'hFFFF_FFFF);
      end else begin
        exp_d = sb.pop_front();
        check($sformatf("row%0d_sb_data", idx), out_data, exp_d);
      end
    end
    if (r.fl) sb.delete();
    else if (r.iv && r.e_irdy) sb.push_back(r.id);
    @(negedge clk);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int seg1;

  initial begin
    // Streaming, out_ready=1
    tbl.push_back(row(0, 1, 8'h01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 1, 8'h02, 1, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 1, 8'h03, 1, 1, 0, 8'h00, 2));
    tbl.push_back(row(0, 1, 8'h04, 1, 1, 1, 8'h01, 3));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h02, 3));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h03, 2));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h04, 1));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    // Back-pressure with a bubble, then full
    tbl.push_back(row(0, 1, 8'h11, 0, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 0, 8'h00, 0, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 1, 8'h22, 0, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 0, 8'h00, 0, 1, 1, 8'h11, 2));
    tbl.push_back(row(0, 1, 8'h33, 0, 1, 1, 8'h11, 2));
    tbl.push_back(row(0, 1, 8'h55, 0, 0, 1, 8'h11, 3));
    // Release stall from full
    tbl.push_back(row(0, 1, 8'h55, 1, 1, 1, 8'h11, 3));
    tbl.push_back(row(0, 1, 8'h66, 1, 1, 1, 8'h22, 3));
    tbl.push_back(row(0, 1, 8'h77, 1, 1, 1, 8'h33, 3));
    // Flush full pipe while stalled; 0x44 must vanish
    tbl.push_back(row(1, 1, 8'h44, 0, 1, 1, 8'h55, 3));
    tbl.push_back(row(0, 0, 8'h00, 0, 1, 0, 8'h00, 0));
    // Flush a partly filled pipe
    tbl.push_back(row(0, 1, 8'h81, 1, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 1, 8'h82, 1, 1, 0, 8'h00, 1));
    tbl.push_back(row(1, 1, 8'h83, 1, 1, 0, 8'h00, 2));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    // Flush in the same cycle a beat leaves: 0x91 is delivered
    tbl.push_back(row(0, 1, 8'h91, 1, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 1, 8'h92, 1, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 1, 8'h93, 1, 1, 0, 8'h00, 2));
    tbl.push_back(row(1, 1, 8'h94, 1, 1, 1, 8'h91, 3));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    // Fill ahead of the asynchronous reset
    tbl.push_back(row(0, 1, 8'hA1, 0, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 1, 8'hA2, 0, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 1, 8'hA3, 0, 1, 0, 8'h00, 2));
    seg1 = tbl.size();
    // First beat after reset release
    tbl.push_back(row(0, 1, 8'hB1, 1, 1, 0, 8'h00, 0));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 1));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'hB1, 1));
    tbl.push_back(row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));

    // Reset held with a beat offered
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); @(posedge clk); #1;
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_occupancy", occupancy, 0);
    in_valid = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < seg1; i++) do_row(i, tbl[i]);

    // Full and stalled, then asynchronous reset between edges
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_areset_out_valid", out_valid, 1);
    check("pre_areset_out_data", out_data, 8'hA1);
    check("pre_areset_occupancy", occupancy, 3);
    check("pre_areset_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_out_data", out_data, 0);
    check("areset_occupancy", occupancy, 0);
    check("areset_in_ready", in_ready, 1);
    sb.delete();
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b1;

    for (int i = seg1; i < tbl.size(); i++) do_row(i, tbl[i]);

    check("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
